leb128_stream_dec: RTL and testbench

LEB128_STREAM_DEC -- requirements
Module: leb128_stream_dec

---
 rtl/leb128_stream_dec.sv | 113 +++++++++++
 tb/tb_leb128_stream_dec.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_stream_dec.sv
// Streaming LEB128 decoder: one byte per cycle in, one decoded value (with
// byte count and overlong flag) out through a valid/ready handshake.
module leb128_stream_dec #(
    parameter  int W    = 64,
    localparam int MAXB = (W + 6) / 7,
    localparam int LW   = $clog2(MAXB + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode_signed,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_err,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int SW = $clog2(7 * MAXB + 1);

    typedef enum logic [1:0] {
        ACC,
        DONE,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  acc;
    logic [LW-1:0] cnt;
    logic          err;
    logic          sgn;

    logic [SW-1:0] shamt;
    logic [SW-1:0] shamt_next;
    logic [W-1:0]  pay_w;
    logic [W-1:0]  merged;
    logic [W-1:0]  ext_mask;
    logic          sgn_eff;
    logic          last;
    logic          ext_on;

    // Payload of byte k lands at bit 7k; anything shifted past W falls off.
    assign shamt      = SW'(cnt) * SW'(7);
    assign shamt_next = shamt + SW'(7);
    assign pay_w      = {{(W-7){1'b0}}, in_data[6:0]};
    assign merged     = acc | (pay_w << shamt);
    assign ext_mask   = {W{1'b1}} << shamt_next;
    assign sgn_eff    = (cnt == '0) ? mode_signed : sgn;
    assign last       = (cnt == LW'(MAXB - 1));
    assign ext_on     = sgn_eff & in_data[6] & (shamt_next < SW'(W));

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_len   = cnt;
    assign out_err   = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC: begin
                if (in_valid && (!in_data[7] || last)) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = err ? DRAIN : ACC;
            end
            DRAIN: begin
                if (in_valid && !in_data[7]) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
            sgn <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        if (cnt == '0) sgn <= mode_signed;
                        cnt <= cnt + LW'(1);
                        err <= last & in_data[7];
                        // Overlong values keep their raw payload, never extended.
                        if (!in_data[7] && ext_on) acc <= merged | ext_mask;
                        else                       acc <= merged;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_stream_dec.sv
// Scoreboard bench for leb128_stream_dec: a W=64 instance for the main
// scenarios and a W=8 instance for narrow-width truncation.
module tb_leb128_stream_dec;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode_signed = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_len;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [7:0]  in8_data = 8'h00;
    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic        mode8 = 1'b0;
    logic [7:0]  out8_data;
    logic [1:0]  out8_len;
    logic        out8_err;
    logic        out8_valid;
    logic        out8_ready = 1'b0;

    leb128_stream_dec #(.W(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode_signed(mode_signed), .out_data(out_data),
        .out_len(out_len), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    leb128_stream_dec #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in8_data), .in_valid(in8_valid),
        .in_ready(in8_ready), .mode_signed(mode8), .out_data(out8_data),
        .out_len(out8_len), .out_err(out8_err), .out_valid(out8_valid),
        .out_ready(out8_ready)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  len;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] bq[$];
    int tests = 0;
    int fails = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] l, input logic e);
        exp_t x;
        x.data = d;
        x.len  = l;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic put(input logic [7:0] b, input logic ms);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            tests++; fails++;
            $display("FAIL put_timeout in_ready=%b required 1", in_ready);
        end
        in_data = b;
        mode_signed = ms;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic put8(input logic [7:0] b, input logic ms);
        in8_data = b;
        mode8 = ms;
        in8_valid = 1'b1;
        @(posedge clk); #1;
        in8_valid = 1'b0;
    endtask

    task automatic expect_out(input string name);
        int guard = 0;
        exp_t x;
        while (out_valid !== 1'b1 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            fails++;
            $display("FAIL %s_valid out_valid=%b queued=%0d required 1 with a queued result",
                     name, out_valid, sb.size());
        end else begin
            x = sb.pop_front();
            if (out_data !== x.data || out_len !== x.len || out_err !== x.err) begin
                fails++;
                $display("FAIL %s got data=%h len=%0d err=%b required data=%h len=%0d err=%b",
                         name, out_data, out_len, out_err, x.data, x.len, x.err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic enc(input logic [63:0] v, input logic s);
        logic [63:0]        u;
        logic signed [63:0] sv;
        logic [6:0]         b;
        logic               done;
        int                 n;
        n = 0;
        u = v;
        sv = v;
        done = 1'b0;
        while (!done) begin
            if (s) begin
                b = sv[6:0];
                sv = sv >>> 7;
                done = (sv == 0 && !b[6]) || (sv == -1 && b[6]);
            end else begin
                b = u[6:0];
                u = u >> 7;
                done = (u == 0);
            end
            bq.push_back({s, ~done, b});
            n++;
        end
        push(v, 4'(n), 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_data = 8'h05;
        in_valid = 1'b1;
        cyc(2);
        tests++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_len !== 4'd0 ||
            out_err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state valid=%b data=%h len=%0d err=%b in_ready=%b required 0 0 0 0 1",
                     out_valid, out_data, out_len, out_err, in_ready);
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        cyc(2);
        tests++;
        if (out_valid !== 1'b0 || out_len !== 4'd0) begin
            fails++;
            $display("FAIL reset_ignore valid=%b len=%0d required 0 0", out_valid, out_len);
        end
    endtask

    task automatic test_unsigned();
        push(64'h98765, 4'd3, 1'b0);
        put(8'hE5, 1'b0);
        put(8'h8E, 1'b0);
        put(8'h26, 1'b0);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL uleb_latency out_valid=%b required 1", out_valid);
        end
        expect_out("uleb");
    endtask

    task automatic test_signed();
        push(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
        put(8'h7F, 1'b1);
        expect_out("sleb_minus1");
        push(64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
        put(8'hC0, 1'b1);
        put(8'hBB, 1'b0);
        put(8'h78, 1'b0);
        expect_out("sleb_neg");
        push(64'h2000, 4'd2, 1'b0);
        put(8'h80, 1'b0);
        put(8'h40, 1'b1);
        expect_out("mode_late");
    endtask

    task automatic test_overlong();
        push(64'd0, 4'd10, 1'b1);
        repeat (10) put(8'h80, 1'b0);
        expect_out("overlong");
        put(8'h80, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_cont out_valid=%b required 0", out_valid);
        end
        put(8'h00, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_end out_valid=%b required 0", out_valid);
        end
        push(64'd5, 4'd1, 1'b0);
        put(8'h05, 1'b0);
        expect_out("after_drain");
    endtask

    task automatic test_backpressure();
        push(64'h98765, 4'd3, 1'b0);
        put(8'hE5, 1'b0);
        put(8'h8E, 1'b0);
        put(8'h26, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            tests++;
            if (out_valid !== 1'b1 || out_data !== 64'h98765 || out_len !== 4'd3 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d valid=%b data=%h len=%0d in_ready=%b required 1 98765 3 0",
                         i, out_valid, out_data, out_len, in_ready);
            end
        end
        expect_out("bp_release");
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_after in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_stall();
        push(64'h98765, 4'd3, 1'b0);
        put(8'hE5, 1'b0);
        cyc(3);
        tests++;
        if (out_valid !== 1'b0 || out_len !== 4'd1) begin
            fails++;
            $display("FAIL stall_hold valid=%b cnt=%0d required 0 1", out_valid, out_len);
        end
        put(8'h8E, 1'b0);
        cyc(2);
        put(8'h26, 1'b0);
        expect_out("stall");
    endtask

    task automatic test_reset_mid();
        put(8'hE5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_len !== 4'd0 || out_data !== 64'd0) begin
            fails++;
            $display("FAIL rst_mid valid=%b len=%0d data=%h required 0 0 0", out_valid, out_len, out_data);
        end
        #2 rst_n = 1'b1;
        cyc(1);
        push(64'd5, 4'd1, 1'b0);
        put(8'h05, 1'b0);
        expect_out("rst_mid_next");
        put(8'h0A, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_done valid=%b data=%h in_ready=%b required 0 0 1", out_valid, out_data, in_ready);
        end
        #2 rst_n = 1'b1;
        cyc(1);
        push(64'd5, 4'd1, 1'b0);
        put(8'h05, 1'b0);
        expect_out("rst_done_next");
    endtask

    task automatic test_w8();
        put8(8'hFF, 1'b1);
        put8(8'h7F, 1'b1);
        tests++;
        if (out8_valid !== 1'b1 || out8_data !== 8'hFF || out8_len !== 2'd2 || out8_err !== 1'b0) begin
            fails++;
            $display("FAIL w8_sleb valid=%b data=%h len=%0d err=%b required 1 ff 2 0",
                     out8_valid, out8_data, out8_len, out8_err);
        end
        out8_ready = 1'b1;
        cyc(1);
        out8_ready = 1'b0;
        put8(8'h80, 1'b0);
        put8(8'h81, 1'b0);
        tests++;
        if (out8_valid !== 1'b1 || out8_data !== 8'h80 || out8_len !== 2'd2 || out8_err !== 1'b1) begin
            fails++;
            $display("FAIL w8_overlong valid=%b data=%h len=%0d err=%b required 1 80 2 1",
                     out8_valid, out8_data, out8_len, out8_err);
        end
        out8_ready = 1'b1;
        cyc(1);
        out8_ready = 1'b0;
        put8(8'h00, 1'b0);
        put8(8'h45, 1'b1);
        tests++;
        if (out8_valid !== 1'b1 || out8_data !== 8'hC5 || out8_len !== 2'd1 || out8_err !== 1'b0) begin
            fails++;
            $display("FAIL w8_ext valid=%b data=%h len=%0d err=%b required 1 c5 1 0",
                     out8_valid, out8_data, out8_len, out8_err);
        end
        out8_ready = 1'b1;
        cyc(1);
        out8_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nv;
        nv = 16;
        bq.delete();
        for (int i = 0; i < nv; i++)
            enc({$urandom, $urandom} >> $urandom_range(0, 63), 1'(i % 2));
        out_ready = 1'b1;
        fork
            begin
                while (bq.size() > 0) begin
                    logic [8:0] e;
                    e = bq.pop_front();
                    put(e[7:0], e[8]);
                end
            end
            begin
                int got = 0;
                int guard = 0;
                exp_t x;
                while (got < nv && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid === 1'b1) begin
                        tests++;
                        x = sb.pop_front();
                        if (out_data !== x.data || out_len !== x.len || out_err !== x.err) begin
                            fails++;
                            $display("FAIL b2b_%0d got data=%h len=%0d err=%b required data=%h len=%0d err=%b",
                                     got, out_data, out_len, out_err, x.data, x.len, x.err);
                        end
                        got++;
                    end
                end
                if (got < nv) begin
                    tests++; fails++;
                    $display("FAIL b2b_timeout outputs=%0d required %0d", got, nv);
                end
            end
        join
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overlong();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_w8();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
